mesh_term_injector: RTL

- Terminal-side injection stage that sits directly upstream of one mesh_gnrtr edge port.
- Accepts host requests as {destination row, destination column, routing mode, payload}, assembles mesh packets and buffers them in a FIFO.
- Presents buffered packets to the router through the router's terminal-input handshake: pndng_i_in, data_out_i_in and popin.
- Drops requests addressed to non-existent terminals and counts them.

---
 rtl/mesh_term_injector.sv | 86 ++++++++
 1 files changed

// File: rtl/mesh_term_injector.sv
// mesh_term_injector: host-to-mesh injection FIFO that feeds one router terminal input.
// Optional MESH_INJ_SEQ_TAG_EN stamps an 8-bit sequence tag into the top payload byte.
module mesh_term_injector #(
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int SELF_ROW   = 0,
  parameter int SELF_COL   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_row,
  input  logic [3:0]                    in_col,
  input  logic                          in_mode,
  input  logic [pckg_sz-18:0]           in_payload,
  output logic                          pndng_i_in,
  output logic [pckg_sz-1:0]            data_out_i_in,
  input  logic                          popin,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(fifo_depth):0]   occupancy,
  output logic                          err_underflow
);
  localparam int AW = $clog2(fifo_depth);
  localparam logic [3:0] RN = 4'(ROWS);
  localparam logic [3:0] R1 = 4'(ROWS + 1);
  localparam logic [3:0] CN = 4'(COLUMS);
  localparam logic [3:0] C1 = 4'(COLUMS + 1);
  localparam bit SELF_OK = ((SELF_ROW == 0 || SELF_ROW == ROWS + 1) && SELF_COL >= 1 && SELF_COL <= COLUMS) ||
                           ((SELF_COL == 0 || SELF_COL == COLUMS + 1) && SELF_ROW >= 1 && SELF_ROW <= ROWS);
  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] occ_q, occ_d;
  logic [15:0] drop_q, drop_d;
  logic err_q, err_d;
  logic [pckg_sz-18:0] pay;
  logic dest_ok, push, drop, pop;
  // Terminals exist only on the mesh rim, excluding the four corners.
  assign dest_ok = ((in_row == 4'd0 || in_row == R1) && in_col != 4'd0 && in_col <= CN) ||
                   ((in_col == 4'd0 || in_col == C1) && in_row != 4'd0 && in_row <= RN);
  assign in_ready = !occ_q[AW];
  assign push = in_valid && in_ready && dest_ok;
  assign drop = in_valid && in_ready && !dest_ok;
  assign pop  = popin && occ_q != '0;
`ifdef MESH_INJ_SEQ_TAG_EN
  logic [7:0] seq_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) seq_q <= '0;
    else if (push) seq_q <= seq_q + 8'd1;
  assign pay = {seq_q, in_payload[pckg_sz-26:0]};
`else
  assign pay = in_payload;
`endif
  always_comb begin
    wr_d   = push ? wr_q + AW'(1) : wr_q;
    rd_d   = pop ? rd_q + AW'(1) : rd_q;
    occ_d  = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    err_d  = err_q || (popin && occ_q == '0);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {8'h00, in_row, in_col, in_mode, pay};
  always_ff @(posedge clk)
    if (reset) assert (SELF_OK);
  assign pndng_i_in    = occ_q != '0;
  assign data_out_i_in = pndng_i_in ? mem_q[rd_q] : '0;
  assign occupancy     = occ_q;
  assign drop_cnt      = drop_q;
  assign err_underflow = err_q;
endmodule
